// File: rtl/brq_pkg.sv
// Shared types and sizing helpers for the branch resolve queue.
// Stats counters are built only when BRQ_STATS_EN is defined.
package brq_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic valid;
    logic pred;
  } entry_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-facing signal bundle of the branch resolve queue.
// The queue uses the slave modport; the surrounding pipeline uses master.
interface branch_resolve_queue_if
  import brq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);

  logic             issue_valid;
  logic             issue_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             resolve_ready;
  logic             mispredict;
  logic             pred_request;
  logic             pred_result;
  logic             pred_taken;
  logic             pred_in;
  logic [CNT_W-1:0] resolved_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output issue_valid, resolve_valid, resolve_taken, pred_in,
    input  issue_ready, resolve_ready, mispredict, pred_request,
           pred_result, pred_taken, resolved_cnt, mispredict_cnt
  );

  modport slave (
    input  issue_valid, resolve_valid, resolve_taken, pred_in,
    output issue_ready, resolve_ready, mispredict, pred_request,
           pred_result, pred_taken, resolved_cnt, mispredict_cnt
  );

endinterface

// File: rtl/brq_update_buf.sv
// One-entry predictor training buffer; a pending update is only sent in
// cycles where the predictor is not being asked for a new prediction.
module brq_update_buf (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_taken,
  input  logic pred_request,
  output logic pending,
  output logic pred_result,
  output logic pred_taken
);

  logic taken_q;

  assign pred_result = pending & ~pred_request;
  assign pred_taken  = taken_q;

  // A reload on the send edge keeps the buffer occupied with the new outcome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
      taken_q <= 1'b0;
    end else if (load) begin
      pending <= 1'b1;
      taken_q <= load_taken;
    end else if (pred_result) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker of in-flight conditional branches: captures predictions,
// flags mispredicts at resolve, and trains the predictor. Option: BRQ_STATS_EN.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_resolve_queue_if.slave bus
);

  localparam int unsigned      PTR_W    = ptr_w(DEPTH);
  localparam int unsigned      OCC_W    = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] cap_idx;
  logic [OCC_W-1:0] count;
  logic             cap_pending;
  logic             mispredict_q;

  entry_t head_entry;
  logic   has_room;
  logic   issue_want;
  logic   issue_fire;
  logic   resolve_fire;
  logic   mismatch;
  logic   flush;
  logic   upd_pending;

  assign head_entry = mem[head];
  assign has_room   = count < OCC_FULL;
  assign issue_want = bus.issue_valid & has_room;

  // Gating resolve on the flush-free issue intent breaks the issue/flush loop;
  // whenever it blocks a resolve, pred_request is high anyway.
  assign bus.resolve_ready = head_entry.valid & (~upd_pending | ~issue_want);
  assign resolve_fire      = bus.resolve_valid & bus.resolve_ready;
  assign mismatch          = head_entry.pred ^ bus.resolve_taken;
  assign flush             = resolve_fire & mismatch;

  assign bus.issue_ready  = has_room & ~flush;
  assign issue_fire       = bus.issue_valid & bus.issue_ready;
  assign bus.pred_request = issue_fire;
  assign bus.mispredict   = mispredict_q;

  // Ring buffer, pointers, occupancy and the prediction capture slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      head         <= '0;
      tail         <= '0;
      cap_idx      <= '0;
      count        <= '0;
      cap_pending  <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      mispredict_q <= flush;
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
        head        <= tail;
        count       <= '0;
        cap_pending <= 1'b0;
      end else begin
        if (cap_pending) begin
          mem[cap_idx] <= '{valid: 1'b1, pred: bus.pred_in};
        end
        if (issue_fire) begin
          mem[tail] <= '0;
          tail      <= tail + PTR_W'(1);
          cap_idx   <= tail;
        end
        cap_pending <= issue_fire;
        if (resolve_fire) begin
          mem[head].valid <= 1'b0;
          head            <= head + PTR_W'(1);
        end
        count <= count + OCC_W'(issue_fire) - OCC_W'(resolve_fire);
      end
    end
  end

  brq_update_buf u_update_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (resolve_fire),
    .load_taken   (bus.resolve_taken),
    .pred_request (issue_fire),
    .pending      (upd_pending),
    .pred_result  (bus.pred_result),
    .pred_taken   (bus.pred_taken)
  );

`ifdef BRQ_STATS_EN
  logic [CNT_W-1:0] resolved_q;
  logic [CNT_W-1:0] mispred_q;

  // Saturating resolve and mispredict counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolved_q <= '0;
      mispred_q  <= '0;
    end else begin
      if (resolve_fire && (resolved_q != '1)) begin
        resolved_q <= resolved_q + CNT_W'(1);
      end
      if (flush && (mispred_q != '1)) begin
        mispred_q <= mispred_q + CNT_W'(1);
      end
    end
  end

  assign bus.resolved_cnt   = resolved_q;
  assign bus.mispredict_cnt = mispred_q;
`else
  assign bus.resolved_cnt   = '0;
  assign bus.mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: fill/wrap, single branch, flush,
// predictor port conflict, capture cancel, stats and mid-run reset.
module tb_branch_resolve_queue;
  import brq_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;
`ifdef BRQ_STATS_EN
  localparam logic [31:0] EXP_RES = 32'd14;
  localparam logic [31:0] EXP_MIS = 32'd2;
`else
  localparam logic [31:0] EXP_RES = 32'd0;
  localparam logic [31:0] EXP_MIS = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_queue_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs mid-cycle; checks follow 1 time unit later.
  task automatic step(input logic iv, input logic rv, input logic rt, input logic pi);
    @(negedge clk);
    bus.issue_valid   = iv;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    bus.pred_in       = pi;
    #1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.pred_in       = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step(0, 0, 0, 0);
    chk("rst_issue_ready", bus.issue_ready, 1);
    chk("rst_resolve_ready", bus.resolve_ready, 0);
    chk("rst_pred_request", bus.pred_request, 0);
    chk("rst_pred_result", bus.pred_result, 0);
    chk("rst_mispredict", bus.mispredict, 0);
    chk("rst_resolved_cnt", bus.resolved_cnt, 0);
    chk("rst_mispredict_cnt", bus.mispredict_cnt, 0);
    rst_n = 1'b1;

    // Full: four issues into slots 0..3
    step(1, 0, 0, 0);
    chk("full_issue_ready0", bus.issue_ready, 1);
    chk("full_pred_request0", bus.pred_request, 1);
    step(1, 0, 0, 0);
    chk("full_not_valid_yet", bus.resolve_ready, 0);
    step(1, 0, 0, 0);
    chk("full_head_valid", bus.resolve_ready, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("full_issue_ready", bus.issue_ready, 0);
    chk("full_pred_request", bus.pred_request, 0);
    step(0, 1, 0, 0);
    chk("full_resolve_ready", bus.resolve_ready, 1);
    // Fifth issue lands in slot 0 with prediction 1
    step(1, 0, 0, 0);
    chk("wrap_issue_ready", bus.issue_ready, 1);
    chk("wrap_pred_request", bus.pred_request, 1);
    chk("wrap_result_blocked", bus.pred_result, 0);
    step(0, 0, 0, 1);
    chk("wrap_pred_result", bus.pred_result, 1);
    chk("wrap_pred_taken", bus.pred_taken, 0);
    step(0, 1, 0, 0);
    chk("wrap_rr1", bus.resolve_ready, 1);
    step(0, 1, 0, 0);
    chk("wrap_mp1", bus.mispredict, 0);
    step(0, 1, 0, 0);
    chk("wrap_mp2", bus.mispredict, 0);
    step(0, 1, 1, 0);
    chk("wrap_rr4", bus.resolve_ready, 1);
    chk("wrap_no_flush", bus.issue_ready, 1);
    step(0, 0, 0, 0);
    chk("wrap_order_mp", bus.mispredict, 0);
    chk("wrap_empty", bus.resolve_ready, 0);
    chk("wrap_upd_result", bus.pred_result, 1);
    chk("wrap_upd_taken", bus.pred_taken, 1);

    // Single branch, correct prediction
    step(1, 0, 0, 0);
    chk("single_pred_request", bus.pred_request, 1);
    step(0, 0, 0, 0);
    chk("single_not_valid", bus.resolve_ready, 0);
    step(0, 1, 0, 0);
    chk("single_resolve_ready", bus.resolve_ready, 1);
    step(0, 0, 0, 0);
    chk("single_mispredict", bus.mispredict, 0);
    chk("single_pred_result", bus.pred_result, 1);
    chk("single_pred_taken", bus.pred_taken, 0);
    chk("single_empty", bus.resolve_ready, 0);
    step(0, 0, 0, 0);
    chk("single_result_once", bus.pred_result, 0);

    // Mispredict flush with three in flight
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("flush_resolve_ready", bus.resolve_ready, 1);
    chk("flush_blocks_issue", bus.issue_ready, 0);
    step(0, 0, 0, 0);
    chk("flush_mispredict", bus.mispredict, 1);
    chk("flush_empty", bus.resolve_ready, 0);
    chk("flush_pred_result", bus.pred_result, 1);
    chk("flush_pred_taken", bus.pred_taken, 1);
    chk("flush_issue_ready", bus.issue_ready, 1);
    step(0, 0, 0, 0);
    chk("flush_pulse_end", bus.mispredict, 0);

    // Port conflict: issue held high while resolving
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("conf_resolve1", bus.resolve_ready, 1);
    step(1, 1, 0, 0);
    chk("conf_request_a", bus.pred_request, 1);
    chk("conf_result_a", bus.pred_result, 0);
    chk("conf_stall_a", bus.resolve_ready, 0);
    step(1, 1, 0, 0);
    chk("conf_result_b", bus.pred_result, 0);
    chk("conf_stall_b", bus.resolve_ready, 0);
    step(1, 1, 0, 0);
    chk("conf_full", bus.issue_ready, 0);
    chk("conf_gap_result", bus.pred_result, 1);
    chk("conf_gap_resolve", bus.resolve_ready, 1);
    step(0, 0, 0, 0);
    chk("conf_reload_result", bus.pred_result, 1);
    chk("conf_reload_taken", bus.pred_taken, 0);
    chk("conf_mispredict", bus.mispredict, 0);

    // Capture cancel: issue, then mismatching resolve of an older head
    step(1, 0, 0, 0);
    chk("cancel_issue", bus.issue_ready, 1);
    step(0, 1, 1, 1);
    chk("cancel_resolve_ready", bus.resolve_ready, 1);
    step(0, 0, 0, 1);
    chk("cancel_mispredict", bus.mispredict, 1);
    chk("cancel_empty", bus.resolve_ready, 0);
    chk("cancel_issue_ready", bus.issue_ready, 1);
    // Walk three branches round so the head reaches the cancelled slot
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("cancel_rr1", bus.resolve_ready, 1);
    step(0, 1, 0, 0);
    chk("cancel_rr2", bus.resolve_ready, 1);
    step(0, 1, 0, 0);
    chk("cancel_rr3", bus.resolve_ready, 1);
    step(0, 0, 0, 0);
    chk("cancel_slot_stale", bus.resolve_ready, 0);
    chk("cancel_walk_mp", bus.mispredict, 0);

    // Stats, then reset with an update still pending
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("stats_pending", bus.pred_result, 1);
    chk("stats_resolved", bus.resolved_cnt, EXP_RES);
    chk("stats_mispredict", bus.mispredict_cnt, EXP_MIS);
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    chk("rst2_resolved", bus.resolved_cnt, 0);
    chk("rst2_mispredict_cnt", bus.mispredict_cnt, 0);
    chk("rst2_pred_result", bus.pred_result, 0);
    chk("rst2_resolve_ready", bus.resolve_ready, 0);
    chk("rst2_issue_ready", bus.issue_ready, 1);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("rst2_mispredict", bus.mispredict, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
